instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 138 +++++++++++++
 tb/tb_instruction_fetch.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: fetch PC, single-outstanding memory request FSM and a small in-order instruction buffer.
// Define IFETCH_BUFFER2_EN for a two-entry buffer; the default build keeps a single holding register.
module instruction_fetch #(
   parameter int SIZE    = 6,
   parameter int INSTR_W = 16
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Enable,
   input  logic               Branch_taken,
   input  logic [SIZE-1:0]    Branch_target,
   output logic               Mem_req,
   output logic [SIZE-1:0]    Mem_addr,
   input  logic               Mem_ack,
   input  logic [INSTR_W-1:0] Mem_data,
   output logic               Instr_valid,
   input  logic               Instr_ready,
   output logic [INSTR_W-1:0] Instr_out,
   output logic [SIZE-1:0]    PC_out
);

`ifdef IFETCH_BUFFER2_EN
   localparam int unsigned DEPTH = 2;
`else
   localparam int unsigned DEPTH = 1;
`endif

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t               state;
   state_t               state_next;
   logic                 issue;
   logic                 accept;
   logic                 pop;
   logic                 discard;
   logic [1:0]           count;
   logic [SIZE-1:0]      fetch_pc;
   logic [SIZE-1:0]      req_addr;
   int unsigned          push_idx;
   logic [INSTR_W-1:0]   buf_data [DEPTH];
   logic [SIZE-1:0]      buf_pc   [DEPTH];

   assign Instr_valid = (count != 2'd0);
   assign Instr_out   = buf_data[0];
   assign PC_out      = buf_pc[0];
   assign Mem_req     = (state == S_WAIT);
   assign Mem_addr    = req_addr;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A redirect in IDLE holds off the issue so the next request already uses the new target.
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      accept     = 1'b0;
      case (state)
         S_IDLE: begin
            if (Enable && !Branch_taken && (count < 2'(DEPTH))) begin
               issue      = 1'b1;
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (Mem_ack) begin
               accept     = !discard && !Branch_taken;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      pop      = Instr_valid && Instr_ready;
      push_idx = 32'(count) - (pop ? 32'd1 : 32'd0);
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         fetch_pc <= '0;
         req_addr <= '0;
         discard  <= 1'b0;
      end else begin
         if (issue) begin
            req_addr <= fetch_pc;
         end
         if (Branch_taken) begin
            fetch_pc <= Branch_target;
         end else if (accept) begin
            fetch_pc <= fetch_pc + 1'b1;
         end
         // A redirect during the ack cycle drops that response directly; only a still-pending one needs the flag.
         if (state == S_WAIT) begin
            if (Mem_ack) begin
               discard <= 1'b0;
            end else if (Branch_taken) begin
               discard <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         count <= 2'd0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            buf_data[i] <= '0;
            buf_pc[i]   <= '0;
         end
      end else if (Branch_taken) begin
         count <= 2'd0;
      end else begin
         if (pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
               buf_data[i] <= buf_data[i+1];
               buf_pc[i]   <= buf_pc[i+1];
            end
         end
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (accept && (i == push_idx)) begin
               buf_data[i] <= Mem_data;
               buf_pc[i]   <= req_addr;
            end
         end
         count <= count + {1'b0, accept} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected request addresses and {PC, instruction} pairs are queued by the stimulus
// and consumed by independent monitors. Memory word at address a is {4'hA, a, ~a}.
module tb_instruction_fetch;
   localparam int SIZE    = 6;
   localparam int INSTR_W = 16;
`ifdef IFETCH_BUFFER2_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic               Clock;
   logic               Reset;
   logic               Enable;
   logic               Branch_taken;
   logic [SIZE-1:0]    Branch_target;
   logic               Mem_req;
   logic [SIZE-1:0]    Mem_addr;
   logic               Mem_ack;
   logic [INSTR_W-1:0] Mem_data;
   logic               Instr_valid;
   logic               Instr_ready;
   logic [INSTR_W-1:0] Instr_out;
   logic [SIZE-1:0]    PC_out;

   int tests = 0;
   int fails = 0;
   int req_count = 0;
   logic prev_req = 1'b0;
   logic [SIZE-1:0] prev_addr = '0;
   logic auto_ack = 1'b0;
   logic manual_ack = 1'b0;
   int ack_delay = 0;
   int wait_cnt = 0;

   logic [SIZE-1:0]           exp_addr_q  [$];
   logic [SIZE+INSTR_W-1:0]   exp_instr_q [$];

   instruction_fetch #(.SIZE(SIZE), .INSTR_W(INSTR_W)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .Enable(Enable),
      .Branch_taken(Branch_taken),
      .Branch_target(Branch_target),
      .Mem_req(Mem_req),
      .Mem_addr(Mem_addr),
      .Mem_ack(Mem_ack),
      .Mem_data(Mem_data),
      .Instr_valid(Instr_valid),
      .Instr_ready(Instr_ready),
      .Instr_out(Instr_out),
      .PC_out(PC_out)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [INSTR_W-1:0] mem_word(input logic [SIZE-1:0] a);
      return {4'hA, a, ~a};
   endfunction

   assign Mem_data = mem_word(Mem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // memory responder: acks ack_delay cycles into a request, or when the stimulus asks for a manual ack
   initial begin
      Mem_ack = 1'b0;
      forever begin
         @(posedge Clock);
         #2;
         Mem_ack = manual_ack;
         if (auto_ack && Mem_req) begin
            if (wait_cnt >= ack_delay) begin
               Mem_ack  = 1'b1;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // request monitor
   initial begin
      forever begin
         @(negedge Clock);
         if (Mem_req && !prev_req) begin
            req_count++;
            if (exp_addr_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL req_unexpected: got addr 0x%0h, expected no request", Mem_addr);
            end else begin
               check("req_addr", 32'(Mem_addr), 32'(exp_addr_q.pop_front()));
            end
         end else if (Mem_req && prev_req) begin
            check("req_stable", 32'(Mem_addr), 32'(prev_addr));
         end
         prev_req  = Mem_req;
         prev_addr = Mem_addr;
      end
   end

   // instruction monitor
   initial begin
      forever begin
         @(negedge Clock);
         if (Instr_valid && Instr_ready) begin
            if (exp_instr_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL instr_unexpected: got pc 0x%0h instr 0x%0h, expected none", PC_out, Instr_out);
            end else begin
               check("instr", 32'({PC_out, Instr_out}), 32'(exp_instr_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic do_reset();
      Reset        = 1'b0;
      Enable       = 1'b0;
      Branch_taken = 1'b0;
      manual_ack   = 1'b0;
      auto_ack     = 1'b0;
      ack_delay    = 0;
      step(2);
      Reset = 1'b1;
      step(1);
   endtask

   task automatic branch(input logic [SIZE-1:0] target);
      Branch_taken  = 1'b1;
      Branch_target = target;
      step(1);
      Branch_taken  = 1'b0;
   endtask

   task automatic wait_reqs(input string name, input int target);
      int n = 0;
      while (req_count < target && n < 60) begin
         step(1);
         n++;
      end
      check(name, (req_count >= target) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_addr_q.size() != 0 || exp_instr_q.size() != 0) && n < 60) begin
         step(1);
         n++;
      end
      check(name, 32'(exp_addr_q.size() + exp_instr_q.size()), 32'd0);
   endtask

   initial begin
      int base;
      Reset         = 1'b0;
      Enable        = 1'b1;
      Branch_taken  = 1'b0;
      Branch_target = '0;
      Instr_ready   = 1'b1;
      step(2);

      // reset state, even with Enable high
      check("rst_mem_req", 32'(Mem_req), 32'd0);
      check("rst_mem_addr", 32'(Mem_addr), 32'd0);
      check("rst_valid", 32'(Instr_valid), 32'd0);
      check("rst_instr", 32'(Instr_out), 32'd0);
      check("rst_pc", 32'(PC_out), 32'd0);

      // sequential fetch 0..3
      exp_addr_q.push_back(6'd0);
      exp_addr_q.push_back(6'd1);
      exp_addr_q.push_back(6'd2);
      exp_addr_q.push_back(6'd3);
      exp_instr_q.push_back({6'd0, 16'hA03F});
      exp_instr_q.push_back({6'd1, 16'hA07E});
      exp_instr_q.push_back({6'd2, 16'hA0BD});
      exp_instr_q.push_back({6'd3, 16'hA0FC});
      base     = req_count;
      auto_ack = 1'b1;
      Reset    = 1'b1;
      wait_reqs("seq_reqs", base + 4);
      Enable = 1'b0;
      wait_drain("seq_drain");

      // decode stalled: fetch stops once the buffer is full
      do_reset();
      Instr_ready = 1'b0;
      auto_ack    = 1'b1;
      exp_addr_q.push_back(6'd0);
`ifdef IFETCH_BUFFER2_EN
      exp_addr_q.push_back(6'd1);
`endif
      base   = req_count;
      Enable = 1'b1;
      step(20);
      check("stall_fetches", 32'(req_count - base), 32'(DEPTH));
      check("stall_req_low", 32'(Mem_req), 32'd0);
      check("stall_valid", 32'(Instr_valid), 32'd1);
      Enable = 1'b0;
      exp_instr_q.push_back({6'd0, 16'hA03F});
`ifdef IFETCH_BUFFER2_EN
      exp_instr_q.push_back({6'd1, 16'hA07E});
`endif
      Instr_ready = 1'b1;
      wait_drain("stall_drain");

      // PC wrap at 63, redirect while Enable low
      do_reset();
      auto_ack = 1'b1;
      branch(6'd63);
      exp_addr_q.push_back(6'd63);
      exp_addr_q.push_back(6'd0);
      exp_instr_q.push_back({6'd63, 16'hAFC0});
      exp_instr_q.push_back({6'd0, 16'hA03F});
      base   = req_count;
      Enable = 1'b1;
      wait_reqs("wrap_reqs", base + 2);
      Enable = 1'b0;
      wait_drain("wrap_drain");

      // redirect while waiting: response for 5 is discarded, next request goes to 0x20
      do_reset();
      branch(6'd5);
      exp_addr_q.push_back(6'd5);
      base   = req_count;
      Enable = 1'b1;
      wait_reqs("br_req5", base + 1);
      step(2);
      exp_addr_q.push_back(6'h20);
      exp_instr_q.push_back({6'h20, 16'hA81F});
      branch(6'h20);
      check("br_valid_pending", 32'(Instr_valid), 32'd0);
      check("br_addr_held", 32'(Mem_addr), 32'd5);
      step(2);
      manual_ack = 1'b1;
      step(1);
      manual_ack = 1'b0;
      check("br_valid_discard", 32'(Instr_valid), 32'd0);
      auto_ack = 1'b1;
      wait_reqs("br_req20", base + 2);
      Enable = 1'b0;
      wait_drain("br_drain");

      // Enable falls during WAIT; late ack still buffered, no new request until re-enabled
      do_reset();
      exp_addr_q.push_back(6'd0);
      exp_instr_q.push_back({6'd0, 16'hA03F});
      base   = req_count;
      Enable = 1'b1;
      wait_reqs("en_req0", base + 1);
      Enable = 1'b0;
      step(3);
      manual_ack = 1'b1;
      step(1);
      manual_ack = 1'b0;
      wait_drain("en_drain0");
      step(8);
      check("en_no_req", 32'(req_count - base), 32'd1);
      exp_addr_q.push_back(6'd1);
      exp_instr_q.push_back({6'd1, 16'hA07E});
      auto_ack = 1'b1;
      Enable   = 1'b1;
      wait_reqs("en_req1", base + 2);
      Enable = 1'b0;
      wait_drain("en_drain1");

      // reset during WAIT, stray ack afterwards is ignored
      do_reset();
      exp_addr_q.push_back(6'd0);
      base   = req_count;
      Enable = 1'b1;
      wait_reqs("mr_req", base + 1);
      Enable = 1'b0;
      Reset  = 1'b0;
      #1;
      check("mr_req_dropped", 32'(Mem_req), 32'd0);
      check("mr_valid", 32'(Instr_valid), 32'd0);
      step(1);
      Reset      = 1'b1;
      manual_ack = 1'b1;
      step(1);
      manual_ack = 1'b0;
      check("mr_late_ack_valid", 32'(Instr_valid), 32'd0);
      step(2);
      check("mr_late_ack_valid2", 32'(Instr_valid), 32'd0);
      check("mr_req_idle", 32'(Mem_req), 32'd0);
      exp_addr_q.push_back(6'd0);
      exp_instr_q.push_back({6'd0, 16'hA03F});
      auto_ack = 1'b1;
      Enable   = 1'b1;
      wait_reqs("mr_req_again", base + 2);
      Enable = 1'b0;
      wait_drain("mr_drain");

      step(4);
      check("final_queues", 32'(exp_addr_q.size() + exp_instr_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
